// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame reader: FSM states and the command/payload-length table.
package spi_pkg;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned LEN_W = 16;

  localparam logic [CMD_W-1:0] COMMAND_SAVE_SPRITE = 8'h01;
  localparam logic [CMD_W-1:0] COMMAND_DRAW_SPRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Payload words that follow a command; unknown codes carry no payload.
  function automatic logic [LEN_W-1:0] cmd_len(input logic [31:0] code);
    logic [LEN_W-1:0] len;
    len = '0;
    if (code == 32'(COMMAND_SAVE_SPRITE)) begin
      len = LEN_W'(513);
    end else if (code == 32'(COMMAND_DRAW_SPRITE)) begin
      len = LEN_W'(6);
    end
    return len;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for sck/mosi/cs_n plus registered sampling-edge and chip-select edge pulses.
// A sample pulse is only raised while chip select was already low before this cycle.
module spi_edge_sync #(
  parameter int unsigned SPI_MODE = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  input  logic cs_n,
  output logic sample,
  output logic sample_bit,
  output logic cs_fall,
  output logic cs_rise
);

  localparam logic CPOL        = 1'((SPI_MODE >> 1) & 32'd1);
  localparam logic CPHA        = 1'(SPI_MODE & 32'd1);
  // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling one.
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  logic [1:0] sck_sync_q, sck_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic       sck_prev_q, sck_prev_d;
  logic       cs_prev_q, cs_prev_d;
  logic       sample_q, sample_d;
  logic       bit_q, bit_d;
  logic       cs_fall_q, cs_fall_d;
  logic       cs_rise_q, cs_rise_d;
  logic       sck_edge_c;

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], sck};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    sck_prev_d  = sck_sync_q[1];
    cs_prev_d   = cs_sync_q[1];
    sck_edge_c  = SAMPLE_RISE ? (sck_sync_q[1] & ~sck_prev_q)
                              : (~sck_sync_q[1] & sck_prev_q);
    sample_d    = sck_edge_c & ~cs_prev_q;
    bit_d       = mosi_sync_q[1];
    cs_fall_d   = ~cs_sync_q[1] & cs_prev_q;
    cs_rise_d   = cs_sync_q[1] & ~cs_prev_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= {2{CPOL}};
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sck_prev_q  <= CPOL;
      cs_prev_q   <= 1'b1;
      sample_q    <= 1'b0;
      bit_q       <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      sample_q    <= sample_d;
      bit_q       <= bit_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
    end
  end

  assign sample     = sample_q;
  assign sample_bit = bit_q;
  assign cs_fall    = cs_fall_q;
  assign cs_rise    = cs_rise_q;

endmodule

// File: rtl/spi_frame_reader.sv
// SPI slave frame reader: assembles MSB-first words, decodes a command word and counts its payload.
// Optional saturating error counter enabled by defining SPI_FRAME_READER_ERRCNT_EN.
module spi_frame_reader
  import spi_pkg::*;
#(
  parameter int unsigned WORD_W   = 8,
  parameter int unsigned SPI_MODE = 0,
  parameter int unsigned IDX_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              word_valid,
  output logic [WORD_W-1:0] data,
  output logic [WORD_W-1:0] command,
  output logic [IDX_W-1:0]  data_index,
  output logic              cmd_start,
  output logic              frame_error,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  logic sample, sample_bit, cs_fall, cs_rise;

  spi_edge_sync #(
    .SPI_MODE(SPI_MODE)
  ) u_edge_sync (
    .clock      (clock),
    .reset      (reset),
    .sck        (sck),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .sample     (sample),
    .sample_bit (sample_bit),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  state_e              state_q, state_d;
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]   command_q, command_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    data_index_q, data_index_d;
  logic                word_valid_q, word_valid_d;
  logic                cmd_start_q, cmd_start_d;
  logic                frame_error_q, frame_error_d;
  logic [WORD_W-1:0]   word_c;
  logic                word_done_c;

  // Sample is applied before a same-cycle frame close, so the close sees the post-sample state.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    data_d        = data_q;
    command_d     = command_q;
    len_d         = len_q;
    idx_d         = idx_q;
    data_index_d  = data_index_q;
    word_valid_d  = 1'b0;
    cmd_start_d   = 1'b0;
    frame_error_d = 1'b0;
    word_c        = {shift_q, sample_bit};
    word_done_c   = (bit_cnt_q == CNT_W'(WORD_W - 1));

    if (state_q != IDLE && sample) begin
      if (word_done_c) begin
        bit_cnt_d    = '0;
        shift_d      = '0;
        data_d       = word_c;
        word_valid_d = 1'b1;
        if (state_q == CMD) begin
          command_d    = word_c;
          cmd_start_d  = 1'b1;
          len_d        = cmd_len(32'(word_c));
          idx_d        = '0;
          data_index_d = '0;
          if (len_d != '0) begin
            state_d = PAYLOAD;
          end
        end else begin
          data_index_d = idx_q;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(len_q - LEN_W'(1))) begin
            state_d = CMD;
          end
        end
      end else begin
        shift_d   = word_c[WORD_W-2:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    if (state_q == IDLE && cs_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
      shift_d   = '0;
    end

    if (cs_rise) begin
      frame_error_d = (bit_cnt_d != '0) || (state_d == PAYLOAD);
      state_d       = IDLE;
      bit_cnt_d     = '0;
      shift_d       = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      data_q        <= '0;
      command_q     <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      data_index_q  <= '0;
      word_valid_q  <= 1'b0;
      cmd_start_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      command_q     <= command_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      data_index_q  <= data_index_d;
      word_valid_q  <= word_valid_d;
      cmd_start_q   <= cmd_start_d;
      frame_error_q <= frame_error_d;
    end
  end

`ifdef SPI_FRAME_READER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Counts alongside the frame_error pulse and sticks at 255.
  always_comb begin
    err_count_d = err_count_q;
    if (frame_error_d && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign word_valid  = word_valid_q;
  assign data        = data_q;
  assign command     = command_q;
  assign data_index  = data_index_q;
  assign cmd_start   = cmd_start_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Self-checking bench: one reader per SPI mode, random frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_frame_reader;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned IDX_W  = 16;
  localparam int          HALF   = 4;

  typedef struct packed {
    logic [1:0]  m;
    logic [7:0]  data;
    logic        cs;
    logic [7:0]  cmd;
    logic [15:0] idx;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mosi  = 1'b0;
  logic sck [4];
  logic cs_n [4];
  logic word_valid [4];
  logic cmd_start [4];
  logic frame_error [4];
  logic [7:0]  data [4];
  logic [7:0]  command [4];
  logic [7:0]  err_count [4];
  logic [15:0] data_index [4];

  ev_t act_q[$];
  time act_tq[$];
  ev_t exp_q[$];
  bit  care_q[$];
  int  fe_cnt [4];
  int  exp_fe [4];
  int  exp_errc [4];
  int  errors = 0;
  int  checks = 0;
  time last_edge_t = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_frame_reader #(
      .WORD_W   (WORD_W),
      .SPI_MODE (g),
      .IDX_W    (IDX_W)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .sck         (sck[g]),
      .mosi        (mosi),
      .cs_n        (cs_n[g]),
      .word_valid  (word_valid[g]),
      .data        (data[g]),
      .command     (command[g]),
      .data_index  (data_index[g]),
      .cmd_start   (cmd_start[g]),
      .frame_error (frame_error[g]),
      .err_count   (err_count[g])
    );
  end

  always @(negedge clock) begin
    for (int m = 0; m < 4; m++) begin
      if (word_valid[m] === 1'b1) begin
        act_q.push_back('{2'(m), data[m], cmd_start[m], command[m], data_index[m]});
        act_tq.push_back($time);
      end
      if (frame_error[m] === 1'b1) fe_cnt[m]++;
    end
  end

  function automatic int ref_len(input logic [7:0] w);
    return (w == 8'h01) ? 513 : ((w == 8'h02) ? 6 : 0);
  endfunction

  function automatic logic [7:0] rand_plain();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == 8'h01 || v == 8'h02) v = v | 8'h80;
    return v;
  endfunction

  // Reference: a frame is a list of full words (command, then its payload) plus trailing partial bits.
  task automatic model_frame(input int m, input logic [7:0] words[$], input int partial);
    int len, k;
    logic [7:0] cur;
    bit in_pay;
    len = 0; k = 0; cur = 8'h00; in_pay = 1'b0;
    foreach (words[i]) begin
      if (!in_pay) begin
        cur = words[i];
        len = ref_len(cur);
        exp_q.push_back('{2'(m), cur, 1'b1, cur, 16'd0});
        care_q.push_back(len > 0);
        in_pay = (len > 0);
        k = 0;
      end else begin
        exp_q.push_back('{2'(m), words[i], 1'b0, cur, 16'(k)});
        care_q.push_back(1'b1);
        k++;
        if (k == len) in_pay = 1'b0;
      end
    end
    if (partial > 0 || in_pay) begin
      exp_fe[m]++;
`ifdef SPI_FRAME_READER_ERRCNT_EN
      exp_errc[m] = (exp_errc[m] < 255) ? exp_errc[m] + 1 : 255;
`endif
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clock);
  endtask

  task automatic send_bits(input int m, input logic [7:0] val, input int n);
    logic cpol, cpha;
    cpol = 1'(m >> 1);
    cpha = 1'(m);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = val[i];
        half();
        sck[m] = ~cpol;
        last_edge_t = $time;
        half();
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        mosi = val[i];
        half();
        sck[m] = cpol;
        last_edge_t = $time;
        half();
      end
    end
  endtask

  task automatic frame(input int m, input logic [7:0] words[$], input int partial, input logic [7:0] pbits);
    cs_n[m] = 1'b0;
    half();
    foreach (words[i]) send_bits(m, words[i], 8);
    if (partial > 0) send_bits(m, pbits, partial);
    half();
    cs_n[m] = 1'b1;
    repeat (12) @(negedge clock);
    model_frame(m, words, partial);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({data[m], command[m], data_index[m], word_valid[m], cmd_start[m], frame_error[m], err_count[m]} !== '0) begin
        errors++;
        $display("FAIL reset_m%0d: data=%h cmd=%h idx=%0d wv=%b cs=%b fe=%b ec=%0d, expected all zero",
                 m, data[m], command[m], data_index[m], word_valid[m], cmd_start[m], frame_error[m], err_count[m]);
      end
    end
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (act_q.size() != 0 || fe_cnt[0] + fe_cnt[1] + fe_cnt[2] + fe_cnt[3] != 0) begin
      errors++;
      $display("FAIL reset_release: got %0d words and %0d errors, expected none", act_q.size(),
               fe_cnt[0] + fe_cnt[1] + fe_cnt[2] + fe_cnt[3]);
    end
  endtask

  task automatic test_single_cmd();
    logic [7:0] w[$];
    w = {8'hA5};
    frame(0, w, 0, 8'h00);
    checks++;
    if (act_tq.size() == 0 || act_tq[0] - last_edge_t != 40) begin
      errors++;
      $display("FAIL latency: got %0d ns after sampling edge, expected 40 ns",
               (act_tq.size() == 0) ? -1 : int'(act_tq[0] - last_edge_t));
    end
    checks++;
    if (data[0] !== 8'hA5 || command[0] !== 8'hA5) begin
      errors++;
      $display("FAIL hold: got data=%h cmd=%h, expected A5/A5", data[0], command[0]);
    end
    w = {8'hA5, rand_plain()};
    frame(0, w, 0, 8'h00);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL single_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_draw_payload();
    logic [7:0] w[$];
    w = {8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h2A};
    frame(0, w, 0, 8'h00);
    w = {8'h02};
    for (int i = 0; i < 6; i++) w.push_back(8'($urandom));
    w.push_back(rand_plain());
    frame(0, w, 0, 8'h00);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL draw_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL draw_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fe_cnt[0] != exp_fe[0]) begin
      errors++;
      $display("FAIL draw_errors: got %0d, expected %0d", fe_cnt[0], exp_fe[0]);
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_modes();
    logic [7:0] w[$];
    for (int m = 0; m < 4; m++) begin
      w = {8'h3C, rand_plain()};
      frame(m, w, 0, 8'h00);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL modes_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL modes_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_partial();
    logic [7:0] w[$];
    w = {};
    frame(0, w, 5, 8'($urandom));
    frame(2, w, 3, 8'($urandom));
    checks++;
    if (act_q.size() != 0) begin
      errors++;
      $display("FAIL partial_words: got %0d words, expected 0", act_q.size());
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fe_cnt[m] != exp_fe[m] || err_count[m] !== 8'(exp_errc[m])) begin
        errors++;
        $display("FAIL partial_err_m%0d: got pulses=%0d count=%0d, expected pulses=%0d count=%0d",
                 m, fe_cnt[m], err_count[m], exp_fe[m], exp_errc[m]);
      end
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_long_payload();
    logic [7:0] w[$];
    w = {8'h01};
    for (int i = 0; i < 100; i++) w.push_back(8'($urandom));
    frame(0, w, 0, 8'h00);
    w = {8'h02};
    frame(0, w, 0, 8'h00);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL long_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL long_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fe_cnt[0] != exp_fe[0] || err_count[0] !== 8'(exp_errc[0])) begin
      errors++;
      $display("FAIL long_err: got pulses=%0d count=%0d, expected pulses=%0d count=%0d",
               fe_cnt[0], err_count[0], exp_fe[0], exp_errc[0]);
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  // Last sampling edge and chip-select release land in the same clock.
  task automatic test_same_clock();
    logic [7:0] w[$];
    logic [7:0] v;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? rand_plain() : 8'h02;
      cs_n[0] = 1'b0;
      half();
      send_bits(0, v >> 1, 7);
      mosi = v[0];
      half();
      sck[0] = 1'b1;
      cs_n[0] = 1'b1;
      half();
      sck[0] = 1'b0;
      repeat (12) @(negedge clock);
      w = {v};
      model_frame(0, w, 0);
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL same_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL same_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    checks++;
    if (fe_cnt[0] != exp_fe[0]) begin
      errors++;
      $display("FAIL same_err: got %0d, expected %0d", fe_cnt[0], exp_fe[0]);
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w[$];
    cs_n[0] = 1'b0;
    half();
    send_bits(0, 8'h05, 3);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int m = 0; m < 4; m++) exp_errc[m] = 0;
    reset = 1'b1;
    half();
    half();
    send_bits(0, 8'hFF, 8);
    half();
    cs_n[0] = 1'b1;
    repeat (12) @(negedge clock);
    w = {8'hFF};
    model_frame(0, w, 0);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL rstmid_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (fe_cnt[m] != exp_fe[m] || err_count[m] !== 8'(exp_errc[m])) begin
        errors++;
        $display("FAIL rstmid_err_m%0d: got pulses=%0d count=%0d, expected pulses=%0d count=%0d",
                 m, fe_cnt[m], err_count[m], exp_fe[m], exp_errc[m]);
      end
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[$];
    int m, n, p, t;
    for (int f = 0; f < 8; f++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 9);
      p = $urandom_range(0, 7);
      t = 2 * $urandom_range(1, 3);
      w = {};
      w.push_back(($urandom_range(0, 1) == 1) ? 8'h02 : rand_plain());
      for (int i = 0; i < n; i++) w.push_back(8'($urandom));
      for (int i = 0; i < t; i++) begin
        sck[m] = ~sck[m];
        half();
      end
      frame(m, w, p, 8'($urandom));
    end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d words, expected %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i].m !== exp_q[i].m || act_q[i].data !== exp_q[i].data || act_q[i].cs !== exp_q[i].cs ||
          act_q[i].cmd !== exp_q[i].cmd || (care_q[i] && act_q[i].idx !== exp_q[i].idx)) begin
        errors++;
        $display("FAIL b2b_w%0d: got %p, expected %p", i, act_q[i], exp_q[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fe_cnt[k] != exp_fe[k] || err_count[k] !== 8'(exp_errc[k])) begin
        errors++;
        $display("FAIL b2b_err_m%0d: got pulses=%0d count=%0d, expected pulses=%0d count=%0d",
                 k, fe_cnt[k], err_count[k], exp_fe[k], exp_errc[k]);
      end
    end
    act_q.delete(); act_tq.delete(); exp_q.delete(); care_q.delete();
  endtask

  initial begin
    for (int m = 0; m < 4; m++) begin
      sck[m]      = 1'(m >> 1);
      cs_n[m]     = 1'b1;
      fe_cnt[m]   = 0;
      exp_fe[m]   = 0;
      exp_errc[m] = 0;
    end
    test_reset();
    test_single_cmd();
    test_draw_payload();
    test_modes();
    test_partial();
    test_long_payload();
    test_same_clock();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_frame_reader.md
SPI_FRAME_READER -- requirements
Module: spi_frame_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per received word (4..32).
REQ-002 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0..3 ({CPOL,CPHA}).
REQ-003 SHALL have parameter IDX_W, default 16, meaning the width of data_index and the payload length counter.
REQ-004 SHALL have port clock  input  1  meaning system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port sck  input  1  meaning raw SPI clock, asynchronous to clock.
REQ-007 SHALL have port mosi  input  1  meaning raw SPI data, MSB first.
REQ-008 SHALL have port cs_n  input  1  meaning raw active-low chip select; frames the transfer.
REQ-009 SHALL have port word_valid  output  1  meaning one-cycle pulse per completed word.
REQ-010 SHALL have port data  output  WORD_W  meaning latest completed word, held until the next word.
REQ-011 SHALL have port command  output  WORD_W  meaning the current command word.
REQ-012 SHALL have port data_index  output  IDX_W  meaning the 0-based index of the current payload word.
REQ-013 SHALL have port cmd_start  output  1  meaning one-cycle pulse when a command word is accepted.
REQ-014 SHALL have port frame_error  output  1  meaning one-cycle pulse on a protocol error.
REQ-015 SHALL have port err_count  output  8  meaning the saturating error counter (see Configuration).

Function
REQ-016 SHALL pass sck, mosi and cs_n through two-flop synchronisers before any use.
REQ-017 SHALL sample mosi on the leading sck edge when CPHA=0 and on the trailing edge when CPHA=1; leading = rising if CPOL=0, falling if CPOL=1.
REQ-018 SHALL shift bits in MSB first; after WORD_W samples, data updates and word_valid pulses exactly 4 clock cycles after the raw sampling edge.
REQ-019 SHALL use the FSM states IDLE, CMD and PAYLOAD.
REQ-020 SHALL move from IDLE to CMD when synchronised cs_n falls, clearing the bit counter and shift register.
REQ-021 SHALL, on a word completed in CMD, load command, pulse cmd_start with word_valid, and look up the payload length len from the package table; len=0 stays in CMD, otherwise enter PAYLOAD with data_index=0.
REQ-022 SHALL, on each word in PAYLOAD, present data_index with that word, then increment data_index; when data_index reaches len-1 it returns to CMD on that word.
REQ-023 SHALL keep data_index counting and wrapping modulo 2^IDX_W, never saturating.
REQ-024 SHALL, on cs_n rising from any state, go to IDLE; a partial word (bit counter non-zero) or PAYLOAD not completed pulses frame_error and the partial word is discarded.
REQ-025 SHALL ignore sck edges while cs_n is high.
REQ-026 SHALL process a sampling edge and a cs_n rise that occur in the same clock as: the sample first, then the frame close.
REQ-027 SHALL treat an unknown command as len=0 with no error.

Reset
REQ-028 SHALL, while reset=0, force state=IDLE, data=0, command=0, data_index=0, word_valid=0, cmd_start=0, frame_error=0, err_count=0, synchronisers=idle levels (sck=CPOL, cs_n=1).
REQ-029 SHALL, on reset asserted mid-word, drop the partial word with no output pulse after release.

Configuration
REQ-030 SHALL, with macro SPI_FRAME_READER_ERRCNT_EN defined, increment err_count on each frame_error, saturating at 255.
REQ-031 SHALL, without SPI_FRAME_READER_ERRCNT_EN, tie err_count to 0 and synthesise no counter logic.

Structure
REQ-032 SHALL place the command codes (COMMAND_SAVE_SPRITE=8'h01, COMMAND_DRAW_SPRITE=8'h02), the command-length function (513 and 6 respectively, otherwise 0) and the FSM state enum in the shared package spi_pkg.
REQ-033 SHALL implement the synchronisers plus sampling-edge detection as one sub-module, spi_edge_sync, parameterised by SPI_MODE.

Verification
REQ-034 SHALL cover: mode 0, WORD_W=8, cs_n low, byte 8'hA5 -> data=8'hA5, word_valid 1 cycle, cmd_start 1 cycle, command=8'hA5, state stays CMD.
REQ-035 SHALL cover: 8'h02 followed by 6 bytes 8'h10..8'h15 -> data_index 0..5 paired with those bytes, next byte becomes command.
REQ-036 SHALL cover: modes 1, 2 and 3, each with byte 8'h3C -> data=8'h3C in all modes.
REQ-037 SHALL cover: cs_n raised after 5 bits -> frame_error 1 cycle, no word_valid, err_count=1 (macro on) or 0 (macro off).
REQ-038 SHALL cover: 8'h01, 100 payload bytes, then cs_n high -> frame_error; a new frame with 8'h02 gives cmd_start, data_index=0.
REQ-039 SHALL cover: reset pulsed low mid-byte, then a full byte 8'hFF -> only 8'hFF reported, as a command.
